box_250mhz_p4_ingress_arb: RTL and testbench

Packet-granular round-robin arbiter that shares the single P4 pipeline ingress in the 250 MHz box between NUM_PORTS AXI4-Stream sources, for example QDMA H2C and CMAC RX per port. It locks onto one source from the first beat to the tlast handshake and never interleaves packets. It tags each packet with its source index in the output tuser and produces the P4 user-metadata valid strobe on the first beat. It also keeps a per-source packet counter.

---
 rtl/box_250mhz_p4_ingress_arb_pkg.sv | 18 +
 rtl/box_250mhz_p4_ingress_arb_if.sv | 24 ++
 rtl/box_250mhz_p4_ingress_arb_rr_pick.sv | 37 +++
 rtl/box_250mhz_p4_ingress_arb.sv | 122 ++++++++++++
 tb/tb_box_250mhz_p4_ingress_arb.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/box_250mhz_p4_ingress_arb_pkg.sv
// Shared definitions for the 250 MHz box P4 ingress path.
// Field offsets, output tuser layout and arbiter state encoding.
package p4_box_pkg;

    localparam int SIZE_LSB    = 0;
    localparam int SRC_LSB     = 16;
    localparam int DST_LSB     = 32;
    localparam int IDX_LSB     = 56;
    localparam int IDX_FIELD_W = 8;
    localparam int M_TUSER_W   = 64;
    localparam int CNT_W       = 32;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_e;

endpackage

// File: rtl/box_250mhz_p4_ingress_arb_if.sv
// AXI4-Stream bundle; N lanes packed side by side.
// The master side drives payload and valid, the slave side drives ready.
interface box_250mhz_p4_ingress_arb_if #(
    parameter int N  = 1,
    parameter int DW = 512,
    parameter int UW = 48
);
    logic [N-1:0]      tvalid;
    logic [N*DW-1:0]   tdata;
    logic [N*DW/8-1:0] tkeep;
    logic [N-1:0]      tlast;
    logic [N*UW-1:0]   tuser;
    logic [N-1:0]      tready;

    modport master (
        output tvalid, tdata, tkeep, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tlast, tuser,
        output tready
    );
endinterface

// File: rtl/box_250mhz_p4_ingress_arb_rr_pick.sv
// Rotate-priority encoder: first requester at or after ptr, wrapping.
// Shared with the egress demux/scheduler.
module box_250mhz_rr_pick #(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = 3
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [IDX_W-1:0]     gnt_idx,
    output logic                 any
);

    logic [IDX_W:0] pos;
    logic           hit;

    // Scan farthest-to-nearest so the nearest requester wins last.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        pos     = '0;
        hit     = 1'b0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (pos >= (IDX_W + 1)'(NUM_PORTS))
                pos = pos - (IDX_W + 1)'(NUM_PORTS);
            hit = 1'b0;
            for (int i = 0; i < NUM_PORTS; i++)
                if (pos == (IDX_W + 1)'(i))
                    hit = req[i];
            if (hit) begin
                gnt_idx = pos[IDX_W-1:0];
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/box_250mhz_p4_ingress_arb.sv
// Packet-granular round-robin arbiter feeding the shared P4 ingress.
// Locks a source from first beat to tlast, tags tuser with the source index.
module box_250mhz_p4_ingress_arb
    import p4_box_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int TDATA_W   = 512,
    parameter int TUSER_W   = 48,
    parameter int IDX_W     = 3
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    box_250mhz_p4_ingress_arb_if.slave  s_axis,
    box_250mhz_p4_ingress_arb_if.master m_axis,
    output logic                       user_metadata_valid,
    output logic [NUM_PORTS*CNT_W-1:0] pkt_cnt
);

    arb_state_e                 state_q;
    logic [IDX_W-1:0]           rr_ptr_q;
    logic [IDX_W-1:0]           grant_q;
    logic                       first_beat_q;
    logic [NUM_PORTS*CNT_W-1:0] cnt_q;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               locked;
    logic               hs;
    logic               sel_valid;
    logic               sel_last;
    logic [TDATA_W-1:0]   sel_data;
    logic [TDATA_W/8-1:0] sel_keep;
    logic [TUSER_W-1:0]   sel_user;
    logic [M_TUSER_W-1:0] tuser_out;

    box_250mhz_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req     (s_axis.tvalid),
        .ptr     (rr_ptr_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign locked = (state_q == LOCKED);

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_keep  = '0;
        sel_user  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q == IDX_W'(i)) begin
                sel_valid = s_axis.tvalid[i];
                sel_last  = s_axis.tlast[i];
                sel_data  = s_axis.tdata[i*TDATA_W +: TDATA_W];
                sel_keep  = s_axis.tkeep[i*(TDATA_W/8) +: TDATA_W/8];
                sel_user  = s_axis.tuser[i*TUSER_W +: TUSER_W];
            end
        end
    end

    always_comb begin
        tuser_out = '0;
        tuser_out[TUSER_W-1:0] = sel_user;
        tuser_out[IDX_LSB +: IDX_FIELD_W] = IDX_FIELD_W'(grant_q);
    end

    always_comb begin
        s_axis.tready = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            s_axis.tready[i] = locked && (grant_q == IDX_W'(i))
                               && m_axis.tready;
    end

    assign m_axis.tvalid = locked & sel_valid;
    assign m_axis.tlast  = locked & sel_last;
    assign m_axis.tdata  = sel_data;
    assign m_axis.tkeep  = sel_keep;
    assign m_axis.tuser  = tuser_out;

    assign hs = locked & sel_valid & m_axis.tready;
    assign user_metadata_valid = locked & sel_valid & first_beat_q;
    assign pkt_cnt = cnt_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            first_beat_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick_idx;
                        state_q <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (hs && sel_last) begin
                        state_q      <= IDLE;
                        first_beat_q <= 1'b1;
                        rr_ptr_q     <= (grant_q == IDX_W'(NUM_PORTS - 1))
                                        ? '0 : grant_q + 1'b1;
                        for (int i = 0; i < NUM_PORTS; i++)
                            if (grant_q == IDX_W'(i))
                                cnt_q[i*CNT_W +: CNT_W] <=
                                    cnt_q[i*CNT_W +: CNT_W] + 32'd1;
                    end else if (hs) begin
                        first_beat_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_box_250mhz_p4_ingress_arb.sv
// Bench for the P4 ingress arbiter: directed phases plus random traffic,
// every cycle compared against a packet-level reference model.
module tb_box_250mhz_p4_ingress_arb;

    localparam int P  = 2;
    localparam int DW = 64;
    localparam int KW = DW / 8;
    localparam int UW = 48;
    localparam int IW = 3;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic            umv;
    logic [P*32-1:0] pkt_cnt;

    box_250mhz_p4_ingress_arb_if #(.N(P), .DW(DW), .UW(UW)) s_if ();
    box_250mhz_p4_ingress_arb_if #(.N(1), .DW(DW), .UW(64)) m_if ();

    box_250mhz_p4_ingress_arb #(
        .NUM_PORTS (P),
        .TDATA_W   (DW),
        .TUSER_W   (UW),
        .IDX_W     (IW)
    ) dut (
        .aclk                (aclk),
        .aresetn             (aresetn),
        .s_axis              (s_if),
        .m_axis              (m_if),
        .user_metadata_valid (umv),
        .pkt_cnt             (pkt_cnt)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int failures = 0;

    // Source-side traffic generators
    int            pkts_left [P];
    int            fix_len   [P];
    int            len       [P];
    int            beat      [P];
    logic [DW-1:0] data      [P];
    logic [KW-1:0] keep      [P];
    logic [UW-1:0] user      [P];
    logic          vld       [P];
    logic          rdy_in;
    int            gap_pct = 0;
    int            tr_mode = 0;
    bit            chk_en  = 1'b0;

    // Reference model: who owns the ingress, how many beats of it went out
    int          owner = -1;
    int          ptr   = 0;
    int          sent  = 0;
    logic [31:0] cnt [P];
    longint      cyc   = 0;
    int          mv_seen = 0;
    int          grant_seq [$];
    longint      hs_cyc [$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic new_beat(input int i);
        data[i] = {$urandom, $urandom};
        keep[i] = KW'($urandom);
    endtask

    task automatic new_pkt(input int i);
        beat[i] = 0;
        len[i]  = (fix_len[i] > 0) ? fix_len[i] : int'($urandom_range(4, 1));
        user[i] = UW'({$urandom, $urandom});
        new_beat(i);
    endtask

    task automatic drive();
        for (int i = 0; i < P; i++) begin
            vld[i] = (pkts_left[i] > 0)
                     && (int'($urandom_range(99)) >= gap_pct);
            s_if.tvalid[i]            = vld[i];
            s_if.tlast[i]             = (beat[i] == len[i] - 1);
            s_if.tdata[i*DW +: DW]    = data[i];
            s_if.tkeep[i*KW +: KW]    = keep[i];
            s_if.tuser[i*UW +: UW]    = user[i];
        end
        case (tr_mode)
            0:       rdy_in = 1'b1;
            1:       rdy_in = ~rdy_in;
            default: rdy_in = ($urandom_range(1) == 1);
        endcase
        m_if.tready = rdy_in;
    endtask

    task automatic check_outputs();
        logic         exp_mv;
        logic [P-1:0] exp_rdy;
        logic [P*32-1:0] exp_cnt;
        exp_mv  = 1'b0;
        exp_rdy = '0;
        if (owner >= 0) begin
            exp_mv = vld[owner];
            exp_rdy[owner] = rdy_in;
        end
        for (int i = 0; i < P; i++)
            exp_cnt[i*32 +: 32] = cnt[i];
        chk("m_tvalid", m_if.tvalid, exp_mv);
        chk("s_tready", s_if.tready, exp_rdy);
        chk("user_md_valid", umv, exp_mv && (sent == 0));
        chk("pkt_cnt", pkt_cnt, exp_cnt);
        if (exp_mv) begin
            chk("m_tdata", m_if.tdata, data[owner]);
            chk("m_tkeep", m_if.tkeep, keep[owner]);
            chk("m_tlast", m_if.tlast, beat[owner] == len[owner] - 1);
            chk("m_tuser", m_if.tuser, {8'(owner), 8'h00, user[owner]});
        end
        if (m_if.tvalid) mv_seen++;
        if (m_if.tvalid && m_if.tready) begin
            hs_cyc.push_back(cyc);
            if (umv) grant_seq.push_back(int'(m_if.tuser[63:56]));
        end
    endtask

    task automatic update();
        int  o;
        bit  found;
        cyc++;
        if (!aresetn) begin
            owner = -1;
            ptr   = 0;
            sent  = 0;
            for (int i = 0; i < P; i++) begin
                cnt[i] = '0;
                new_pkt(i);
            end
        end else if (owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < P; k++) begin
                o = (ptr + k) % P;
                if (!found && vld[o]) begin
                    owner = o;
                    sent  = 0;
                    found = 1'b1;
                end
            end
        end else if (vld[owner] && rdy_in) begin
            o = owner;
            if (beat[o] == len[o] - 1) begin
                cnt[o] = cnt[o] + 32'd1;
                ptr    = (o + 1) % P;
                owner  = -1;
                pkts_left[o]--;
                new_pkt(o);
            end else begin
                beat[o]++;
                sent++;
                new_beat(o);
            end
        end
    endtask

    task automatic step();
        drive();
        #1;
        if (chk_en) check_outputs();
        @(posedge aclk);
        update();
        @(negedge aclk);
    endtask

    task automatic run_until_idle(input int budget, input string tag);
        int n;
        int busy;
        n = 0;
        busy = 1;
        while (busy != 0 && n < budget) begin
            step();
            n++;
            busy = (owner >= 0) ? 1 : 0;
            for (int i = 0; i < P; i++) busy += pkts_left[i];
        end
        chk({tag, "_drain"}, busy, 0);
    endtask

    initial begin
        logic [P*32-1:0] fv;
        int n;
        aresetn = 1'b0;
        rdy_in  = 1'b0;
        for (int i = 0; i < P; i++) begin
            pkts_left[i] = 0;
            fix_len[i]   = 0;
            cnt[i]       = '0;
            new_pkt(i);
        end
        repeat (3) step();
        chk_en = 1'b1;
        step();
        chk("rst_tready", s_if.tready, 0);
        chk("rst_mvalid", m_if.tvalid, 0);
        chk("rst_umv", umv, 0);
        chk("rst_cnt", pkt_cnt, 0);
        aresetn = 1'b1;

        // One 3-beat packet on port 0
        fix_len[0] = 3;
        new_pkt(0);
        pkts_left[0] = 1;
        mv_seen = 0;
        repeat (6) step();
        chk("single_mv_cycles", mv_seen, 3);
        chk("single_cnt0", pkt_cnt[31:0], 1);

        // Both ports with 2-beat packets; pointer now sits at port 1
        fix_len[0] = 2;
        fix_len[1] = 2;
        new_pkt(0);
        new_pkt(1);
        pkts_left[0] = 4;
        pkts_left[1] = 4;
        grant_seq.delete();
        run_until_idle(60, "contention");
        chk("contention_pkts", grant_seq.size(), 8);
        for (int k = 0; k < grant_seq.size(); k++)
            chk("contention_order", grant_seq[k], (k + 1) % P);
        chk("contention_cnt0", pkt_cnt[31:0], 5);
        chk("contention_cnt1", pkt_cnt[63:32], 4);

        // Backpressure on a port 1 packet while port 0 also requests
        fix_len[1] = 4;
        new_pkt(1);
        pkts_left[1] = 1;
        tr_mode = 1;
        step();
        fix_len[0] = 2;
        new_pkt(0);
        pkts_left[0] = 1;
        run_until_idle(40, "backpressure");
        tr_mode = 0;

        // Back-to-back single-beat packets on port 1
        fix_len[1] = 1;
        new_pkt(1);
        pkts_left[1] = 4;
        hs_cyc.delete();
        run_until_idle(30, "single_beat");
        chk("single_beat_pkts", hs_cyc.size(), 4);
        for (int k = 1; k < hs_cyc.size(); k++)
            chk("single_beat_spacing", hs_cyc[k] - hs_cyc[k-1], 2);

        // Random traffic with valid gaps and random ready
        gap_pct = 30;
        tr_mode = 2;
        for (int i = 0; i < P; i++) begin
            fix_len[i] = 0;
            new_pkt(i);
            pkts_left[i] = 15;
        end
        run_until_idle(1500, "random");
        gap_pct = 0;
        tr_mode = 0;

        // Counter wrap on port 0
        fv = pkt_cnt;
        fv[31:0] = 32'hFFFF_FFFF;
        force dut.cnt_q = fv;
        #1;
        release dut.cnt_q;
        cnt[0] = 32'hFFFF_FFFF;
        chk("wrap_preload", pkt_cnt[31:0], 32'hFFFF_FFFF);
        fix_len[0] = 2;
        new_pkt(0);
        pkts_left[0] = 1;
        run_until_idle(20, "wrap");
        chk("wrap_cnt0", pkt_cnt[31:0], 0);

        // Reset while beat 1 of a 4-beat packet is on the bus
        fix_len[0] = 4;
        new_pkt(0);
        pkts_left[0] = 1;
        n = 0;
        while (!(owner == 0 && sent == 1) && n < 10) begin
            step();
            n++;
        end
        chk("midrst_reach_beat1", sent, 1);
        aresetn = 1'b0;
        step();
        chk("midrst_tready", s_if.tready, 0);
        chk("midrst_mvalid", m_if.tvalid, 0);
        chk("midrst_umv", umv, 0);
        chk("midrst_ptr", dut.rr_ptr_q, 0);
        chk("midrst_cnt", pkt_cnt, 0);
        aresetn = 1'b1;
        run_until_idle(20, "post_reset");
        chk("post_reset_cnt0", pkt_cnt[31:0], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
